snake_body_buffer: RTL and testbench

//  Downstream of snake_datapath. Keeps the snake body as a circular buffer of

---
 rtl/snake_body_buffer.sv | 186 ++++++++++++++++++
 tb/tb_snake_body_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snake_body_buffer                                                          |
// | Circular buffer of snake head positions; turns each head move into VGA     |
// | pixel writes (erase tail, draw head). Optional SNAKE_SELF_HIT_EN adds the  |
// | body-compare (CHECK) pass and the self_hit flag.                           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module snake_body_buffer #(
   parameter int         MAX_LEN     = 64,
   parameter int         INIT_LEN    = 4,
   parameter int         LEN_W       = 7,
   parameter logic [2:0] BG_COLOUR   = 3'b000,
   parameter logic [2:0] BODY_COLOUR = 3'b010
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             head_valid,
   input  logic [7:0]       head_x,
   input  logic [6:0]       head_y,
   input  logic             grow,
   output logic             plot,
   output logic [7:0]       x,
   output logic [6:0]       y,
   output logic [2:0]       colour,
   output logic             busy,
   output logic [LEN_W-1:0] length,
   output logic             overrun,
   output logic             self_hit
);

   localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(MAX_LEN - 1);
   localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] c_init_len = LEN_W'(INIT_LEN);
   localparam logic [LEN_W-1:0] c_one      = LEN_W'(1);
`ifdef SNAKE_SELF_HIT_EN
   localparam logic c_check_en = 1'b1;
`else
   localparam logic c_check_en = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ERASE = 2'd1,
      S_CHECK = 2'd2,
      S_DRAW  = 2'd3
   } state_t;

   state_t           r_state;
   logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr, r_chk_ptr;
   logic [LEN_W-1:0] r_length, r_credit, r_chk_cnt;
   logic [7:0]       r_head_x;
   logic [6:0]       r_head_y;
   logic             r_plot, r_busy, r_overrun, r_self_hit;
   logic [7:0]       r_x;
   logic [6:0]       r_y;
   logic [2:0]       r_colour;
   logic [7:0]       r_mem_x [MAX_LEN];
   logic [6:0]       r_mem_y [MAX_LEN];

   logic [LEN_W-1:0] w_credit_inc;
   logic             w_grow_move;
   logic             w_hit;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == c_ptr_last) ? '0 : p + PTR_W'(1);
   endfunction

   // A grow pulse coincident with head_valid counts before the move decision.
   assign w_credit_inc = (grow && (r_credit != c_max_len)) ? r_credit + c_one : r_credit;
   assign w_grow_move  = (w_credit_inc != '0) && (r_length < c_max_len);
   assign w_hit        = (r_mem_x[r_chk_ptr] == r_head_x) && (r_mem_y[r_chk_ptr] == r_head_y);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_chk_ptr  <= '0;
         r_chk_cnt  <= '0;
         r_length   <= '0;
         r_credit   <= c_init_len;
         r_head_x   <= '0;
         r_head_y   <= '0;
         r_plot     <= 1'b0;
         r_x        <= '0;
         r_y        <= '0;
         r_colour   <= BG_COLOUR;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
         r_self_hit <= 1'b0;
      end else begin
         r_credit <= w_credit_inc;
         r_plot   <= 1'b0;
         if (head_valid && (r_state != S_IDLE))
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (head_valid) begin
                  r_head_x <= head_x;
                  r_head_y <= head_y;
                  r_busy   <= 1'b1;
                  if (w_grow_move) begin
                     r_credit <= w_credit_inc - c_one;
                     if (c_check_en && (r_length != '0)) begin
                        r_state   <= S_CHECK;
                        r_chk_ptr <= r_rd_ptr;
                        r_chk_cnt <= r_length;
                     end else begin
                        r_state  <= S_DRAW;
                        r_plot   <= 1'b1;
                        r_x      <= head_x;
                        r_y      <= head_y;
                        r_colour <= BODY_COLOUR;
                     end
                  end else begin
                     r_state  <= S_ERASE;
                     r_plot   <= 1'b1;
                     r_x      <= r_mem_x[r_rd_ptr];
                     r_y      <= r_mem_y[r_rd_ptr];
                     r_colour <= BG_COLOUR;
                  end
               end
            end
            S_ERASE: begin
               r_rd_ptr <= f_inc(r_rd_ptr);
               r_length <= r_length - c_one;
               if (c_check_en && (r_length != c_one)) begin
                  r_state   <= S_CHECK;
                  r_chk_ptr <= f_inc(r_rd_ptr);
                  r_chk_cnt <= r_length - c_one;
               end else begin
                  r_state  <= S_DRAW;
                  r_plot   <= 1'b1;
                  r_x      <= r_head_x;
                  r_y      <= r_head_y;
                  r_colour <= BODY_COLOUR;
               end
            end
            S_CHECK: begin
               if (w_hit)
                  r_self_hit <= 1'b1;
               r_chk_ptr <= f_inc(r_chk_ptr);
               r_chk_cnt <= r_chk_cnt - c_one;
               if (r_chk_cnt == c_one) begin
                  r_state  <= S_DRAW;
                  r_plot   <= 1'b1;
                  r_x      <= r_head_x;
                  r_y      <= r_head_y;
                  r_colour <= BODY_COLOUR;
               end
            end
            S_DRAW: begin
               r_wr_ptr <= f_inc(r_wr_ptr);
               r_length <= r_length + c_one;
               r_state  <= S_IDLE;
               r_busy   <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Body storage needs no reset; only entries below length are ever read.
   always_ff @(posedge clk) begin
      if (r_state == S_DRAW) begin
         r_mem_x[r_wr_ptr] <= r_head_x;
         r_mem_y[r_wr_ptr] <= r_head_y;
      end
   end

   assign plot     = r_plot;
   assign x        = r_x;
   assign y        = r_y;
   assign colour   = r_colour;
   assign busy     = r_busy;
   assign length   = r_length;
   assign overrun  = r_overrun;
   assign self_hit = r_self_hit;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_snake_body_buffer                                                       |
// | Randomized moves/grows against a queue-based model of the snake body.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_snake_body_buffer;

   localparam int         MAX_LEN  = 8;
   localparam int         INIT_LEN = 4;
   localparam int         LEN_W    = 4;
   localparam logic [2:0] BG       = 3'b000;
   localparam logic [2:0] BODY     = 3'b010;
`ifdef SNAKE_SELF_HIT_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             head_valid = 1'b0;
   logic [7:0]       head_x = '0;
   logic [6:0]       head_y = '0;
   logic             grow = 1'b0;
   logic             plot, busy, overrun, self_hit;
   logic [7:0]       x;
   logic [6:0]       y;
   logic [2:0]       colour;
   logic [LEN_W-1:0] length;

   snake_body_buffer #(
      .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .LEN_W(LEN_W),
      .BG_COLOUR(BG), .BODY_COLOUR(BODY)
   ) dut (
      .clk(clk), .resetn(resetn), .head_valid(head_valid), .head_x(head_x),
      .head_y(head_y), .grow(grow), .plot(plot), .x(x), .y(y), .colour(colour),
      .busy(busy), .length(length), .overrun(overrun), .self_hit(self_hit)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } ev_t;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
   } pos_t;

   ev_t  evq[$];
   ev_t  mon_ev;
   always @(negedge clk) begin
      if (plot === 1'b1) begin
         mon_ev.cyc = cyc;
         mon_ev.x   = x;
         mon_ev.y   = y;
         mon_ev.c   = colour;
         evq.push_back(mon_ev);
      end
   end

   // Reference model: body as a FIFO of positions, oldest (tail) at the front.
   pos_t body[$];
   int   credit;
   bit   exp_hit, exp_ovr;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int c);
      return (c + 1 > MAX_LEN) ? MAX_LEN : c + 1;
   endfunction

   task automatic do_move(input logic [7:0] hx, input logic [6:0] hy,
                          input bit g, input bit dup, input bit late_grow);
      ev_t  exp_ev[$];
      ev_t  e;
      pos_t tail, h;
      int   k, lcnt, eff, n, nmin;
      bit   gm;
      @(posedge clk); #1;
      evq.delete();
      head_valid = 1'b1;
      head_x     = hx;
      head_y     = hy;
      grow       = g;
      k          = cyc + 1;
      eff = g ? sat_inc(credit) : credit;
      gm  = (eff > 0) && (body.size() < MAX_LEN);
      h.x = hx;
      h.y = hy;
      if (gm) begin
         credit = eff - 1;
         lcnt   = CHECK_EN ? body.size() : 0;
      end else begin
         credit = eff;
         tail   = body.pop_front();
         e.cyc = k; e.x = tail.x; e.y = tail.y; e.c = BG;
         exp_ev.push_back(e);
         lcnt   = CHECK_EN ? body.size() + 1 : 1;
      end
      e.cyc = k + lcnt; e.x = hx; e.y = hy; e.c = BODY;
      exp_ev.push_back(e);
      if (CHECK_EN)
         foreach (body[i]) if (body[i] == h) exp_hit = 1'b1;
      body.push_back(h);

      @(posedge clk); #1;
      head_valid = dup;
      head_x     = ~hx;
      grow       = late_grow;
      if (dup) exp_ovr = 1'b1;
      if (late_grow) credit = sat_inc(credit);
      @(posedge clk); #1;
      head_valid = 1'b0;
      grow       = 1'b0;
      n = 0;
      while ((busy !== 1'b0) && (n < 300)) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
      chk("plot_count", evq.size(), exp_ev.size());
      nmin = (evq.size() < exp_ev.size()) ? evq.size() : exp_ev.size();
      for (int i = 0; i < nmin; i++) begin
         chk("plot_cycle", evq[i].cyc - k, exp_ev[i].cyc - k);
         chk("plot_x", {24'd0, evq[i].x}, {24'd0, exp_ev[i].x});
         chk("plot_y", {25'd0, evq[i].y}, {25'd0, exp_ev[i].y});
         chk("plot_colour", {29'd0, evq[i].c}, {29'd0, exp_ev[i].c});
      end
      chk("length", {28'd0, length}, body.size());
      chk("self_hit", {31'd0, self_hit}, {31'd0, exp_hit});
      chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
   endtask

   task automatic pulse_grow();
      @(posedge clk); #1;
      grow = 1'b1;
      credit = sat_inc(credit);
      @(posedge clk); #1;
      grow = 1'b0;
   endtask

   task automatic model_reset();
      body.delete();
      credit  = INIT_LEN;
      exp_hit = 1'b0;
      exp_ovr = 1'b0;
   endtask

   task automatic reset_mid_move();
      @(posedge clk); #1;
      head_valid = 1'b1;
      head_x     = 8'd9;
      head_y     = 7'd9;
      @(posedge clk); #1;
      head_valid = 1'b0;
      if (CHECK_EN) begin
         @(posedge clk); #1;
      end
      resetn = 1'b0;
      #1;
      chk("abort_plot", {31'd0, plot}, 32'd0);
      chk("abort_length", {28'd0, length}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      evq.delete();
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_plot", evq.size(), 32'd0);
      model_reset();
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_plot", {31'd0, plot}, 32'd0);
      chk("rst_x", {24'd0, x}, 32'd0);
      chk("rst_y", {25'd0, y}, 32'd0);
      chk("rst_colour", {29'd0, colour}, {29'd0, BG});
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_length", {28'd0, length}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      chk("rst_self_hit", {31'd0, self_hit}, 32'd0);
      resetn = 1'b1;

      // Initial growth, steady motion, grow coincident with a move, overrun.
      for (int i = 1; i <= 4; i++) do_move(8'(i), 7'd0, 1'b0, 1'b0, 1'b0);
      do_move(8'd5, 7'd0, 1'b0, 1'b0, 1'b0);
      do_move(8'd6, 7'd0, 1'b1, 1'b0, 1'b0);
      do_move(8'd7, 7'd0, 1'b0, 1'b1, 1'b0);

      // Square loop of length 5 returning onto its own body.
      do_move(8'd7, 7'd1, 1'b0, 1'b0, 1'b0);
      do_move(8'd6, 7'd1, 1'b0, 1'b0, 1'b0);
      do_move(8'd6, 7'd0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) pulse_grow();
      for (int i = 0; i < 30; i++) begin
         do_move(8'($urandom_range(0, 15)), 7'($urandom_range(0, 7)),
                 ($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0);
         if (($urandom % 5) == 0) pulse_grow();
      end

      reset_mid_move();

      for (int i = 0; i < 25; i++) begin
         do_move(8'($urandom_range(0, 3)), 7'($urandom_range(0, 3)),
                 ($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
